// File: rtl/generador_comparador.sv
// rtl/generador_comparador.sv - exhaustive stimulus generator and checker for the 2-bit equality comparator
//
// Walks every {a,b} operand pair (b in the LSBs), waits SETTLE cycles for the
// comparator output to settle, checks aeqb against a==b and records mismatches.
//
// Parameters:
//   WIDTH  - operand width; the sweep covers 2^(2*WIDTH) pairs
//   SETTLE - cycles between an operand update and the aeqb sample (1..15)
//
// Ports:
//   clk, rst_n       - clock (rising edge), asynchronous active-low reset
//   start            - single-cycle pulse, begins a sweep when not busy
//   a, b             - operands driven to the comparator
//   aeqb             - comparator result, expected 1 iff a==b
//   busy, done, pass - sweep in progress / finished (held) / no mismatches
//   err_count        - saturating mismatch count
//   fail_valid       - at least one mismatch recorded
//   fail_a, fail_b   - first mismatching pair
//
// Build option:
//   GEN_COMP_STOP_ON_FAIL_EN - when defined, the first mismatch ends the sweep
//                              with a/b left at the failing pair.

module generador_comparador #(
    parameter int WIDTH  = 2,
    parameter int SETTLE = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [WIDTH-1:0]   a,
    output logic [WIDTH-1:0]   b,
    input  logic               aeqb,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [2*WIDTH:0]   err_count,
    output logic               fail_valid,
    output logic [WIDTH-1:0]   fail_a,
    output logic [WIDTH-1:0]   fail_b
);

    localparam int PW = 2 * WIDTH;
    localparam int EW = 2 * WIDTH + 1;
    localparam logic [3:0] SETTLE_RELOAD = 4'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    pair_q, pair_d;
    logic [3:0]       settle_q, settle_d;
    logic [EW-1:0]    err_q, err_d;
    logic             fv_q, fv_d;
    logic [WIDTH-1:0] fa_q, fa_d;
    logic [WIDTH-1:0] fb_q, fb_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;

    logic             mismatch;
    logic [EW-1:0]    err_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            pair_q   <= '0;
            settle_q <= '0;
            err_q    <= '0;
            fv_q     <= 1'b0;
            fa_q     <= '0;
            fb_q     <= '0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pair_q   <= pair_d;
            settle_q <= settle_d;
            err_q    <= err_d;
            fv_q     <= fv_d;
            fa_q     <= fa_d;
            fb_q     <= fb_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pair_d   = pair_q;
        settle_d = settle_q;
        err_d    = err_q;
        fv_d     = fv_q;
        fa_d     = fa_q;
        fb_d     = fb_q;
        done_d   = done_q;
        pass_d   = pass_q;

        mismatch = (aeqb != (a == b));
        // Saturate rather than wrap so a huge failure count never reads as a pass.
        err_next = (mismatch && (err_q != {EW{1'b1}})) ? err_q + EW'(1) : err_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    pair_d   = '0;
                    settle_d = SETTLE_RELOAD;
                    err_d    = '0;
                    fv_d     = 1'b0;
                    fa_d     = '0;
                    fb_d     = '0;
                    done_d   = 1'b0;
                    pass_d   = 1'b0;
                    state_d  = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (settle_q == 4'd0) begin
                    state_d = S_CHECK;
                end else begin
                    settle_d = settle_q - 4'd1;
                end
            end
            S_CHECK: begin
                err_d = err_next;
                if (mismatch && !fv_q) begin
                    fv_d = 1'b1;
                    fa_d = a;
                    fb_d = b;
                end
`ifdef GEN_COMP_STOP_ON_FAIL_EN
                if (mismatch) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    pass_d  = 1'b0;
                end else
`endif
                if (pair_q == {PW{1'b1}}) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    pass_d  = (err_next == '0);
                end else begin
                    pair_d   = pair_q + PW'(1);
                    settle_d = SETTLE_RELOAD;
                    state_d  = S_SETTLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign a          = pair_q[PW-1:WIDTH];
    assign b          = pair_q[WIDTH-1:0];
    assign busy       = (state_q == S_SETTLE) || (state_q == S_CHECK);
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign fail_valid = fv_q;
    assign fail_a     = fa_q;
    assign fail_b     = fb_q;

endmodule
